// File: rtl/led7seg_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scanner.
package led7seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    PEND_EMPTY,
    PEND_FULL
  } pend_state_t;

  // Active-low a..g (bit 0 = a); dp is handled outside the font.
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/led7seg_scan_hex7seg_font.sv
// Combinational hex-to-7-segment decoder, active-low segments a..g.
module hex7seg_font
  import led7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = FONT[nibble];

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed 4-digit hex display driver with valid/ready input latch.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned GUARD   = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] DIN,
  input  logic [3:0]  DP,
  input  logic        DVALID,
  output logic        DREADY,
  input  logic        BLANK,
  output logic [7:0]  LED,
  output logic [3:0]  SA
);

  localparam int unsigned   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0]         count;
  digit_idx_t            index;
  logic                  tick;
  logic                  frame_end;
  logic                  accept;
  pend_state_t           pend_q;
  pend_state_t           pend_d;
  logic [15:0]           pend_val;
  logic [3:0]            pend_dp;
  logic [15:0]           disp_val;
  logic [3:0]            disp_dp;
  logic [3:0]            nibble;
  logic [6:0]            seg;
  logic [3:0]            digit_on;
  logic                  show;
  logic [7:0]            led_q;
  logic [NUM_DIGITS-1:0] sa_drv;

  assign tick      = (count == CNT_LAST);
  assign frame_end = tick && (index == 2'd3);
  assign DREADY    = (pend_q == PEND_EMPTY);
  assign accept    = DVALID && DREADY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
      index <= '0;
    end else if (tick) begin
      count <= '0;
      index <= index + 2'd1;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) pend_q <= PEND_EMPTY;
    else       pend_q <= pend_d;
  end

  always_comb begin
    pend_d = pend_q;
    case (pend_q)
      PEND_EMPTY: if (DVALID)    pend_d = PEND_FULL;
      PEND_FULL:  if (frame_end) pend_d = PEND_EMPTY;
      default:                   pend_d = PEND_EMPTY;
    endcase
  end

  // Display regs only change at frame_end, so a frame never mixes two values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (accept) begin
        pend_val <= DIN;
        pend_dp  <= DP;
      end
      if (frame_end && pend_q == PEND_FULL) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end
  end

  assign nibble = disp_val[{index, 2'b00} +: 4];

  hex7seg_font u_font (
    .nibble (nibble),
    .seg    (seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] keep;

  // A digit stays lit if it or any higher digit is nonzero or has dp set.
  assign keep = {(|disp_val[15:12]) | disp_dp[3],
                 (|disp_val[11:8])  | disp_dp[2],
                 (|disp_val[7:4])   | disp_dp[1],
                 1'b1};
  assign digit_on = {keep[3], |keep[3:2], |keep[3:1], 1'b1};
`else
  assign digit_on = '1;
`endif

  assign show = (count >= GUARD_C) && !BLANK && digit_on[index];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      led_q  <= SEG_OFF;
      sa_drv <= '0;
    end else if (show) begin
      led_q  <= {~disp_dp[index], seg};
      sa_drv <= NUM_DIGITS'(1) << index;
    end else begin
      led_q  <= SEG_OFF;
      sa_drv <= '0;
    end
  end

  assign LED = led_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_sa
    assign SA[g] = sa_drv[g] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_led7seg_scan.sv
// Randomized self-checking bench for led7seg_scan against a cycle-count reference model.
module tb_led7seg_scan;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned GUARD   = 1;
  localparam int unsigned FRAME   = 4 * CLK_DIV;

  localparam logic [7:0] FONT_REF [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        CLK    = 1'b0;
  logic        RSTN   = 1'b0;
  logic [15:0] DIN    = '0;
  logic [3:0]  DP     = '0;
  logic        DVALID = 1'b0;
  logic        BLANK  = 1'b0;
  wire         DREADY;
  wire  [7:0]  LED;
  wire  [3:0]  sa;

  // Released digit selects read back as 1.
  pullup (sa[0]);
  pullup (sa[1]);
  pullup (sa[2]);
  pullup (sa[3]);

  led7seg_scan #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .DIN    (DIN),
    .DP     (DP),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .BLANK  (BLANK),
    .LED    (LED),
    .SA     (sa)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_cyc counts clocks since reset release.
  int          m_cyc;
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;
  logic        m_full;
  logic [7:0]  exp_led;
  logic [3:0]  exp_sa;
  logic [7:0]  m_font;

  function automatic bit digit_visible(input logic [15:0] v, input logic [3:0] d, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 0) return 1'b1;
    for (int j = idx; j < 4; j++)
      if (v[4*j +: 4] != 4'h0 || d[j]) return 1'b1;
    return 1'b0;
`else
    return (idx >= 0);
`endif
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_cyc = 0; m_disp = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_full = 1'b0;
      exp_led = 8'hFF; exp_sa = 4'hF;
    end else begin
      m_cnt = m_cyc % CLK_DIV;
      m_idx = (m_cyc / CLK_DIV) % 4;
      if (m_cnt < GUARD || BLANK || !digit_visible(m_disp, m_dp, m_idx)) begin
        exp_led = 8'hFF;
        exp_sa  = 4'hF;
      end else begin
        m_font  = FONT_REF[m_disp[4*m_idx +: 4]];
        exp_led = {~m_dp[m_idx], m_font[6:0]};
        exp_sa  = ~(4'b0001 << m_idx);
      end
      if (m_full && (m_cyc % FRAME) == FRAME - 1) begin
        m_disp = m_pval; m_dp = m_pdp; m_full = 1'b0;
      end else if (!m_full && DVALID) begin
        m_pval = DIN; m_pdp = DP; m_full = 1'b1;
      end
      m_cyc++;
    end
  end

  task automatic send(input logic [15:0] v, input logic [3:0] d);
    int w = 0;
    @(negedge CLK);
    while (DREADY !== 1'b1 && w < 4 * FRAME) begin
      @(negedge CLK);
      w++;
    end
    n_tests++;
    if (DREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout got DREADY=%b want 1", DREADY);
    end
    DIN = v; DP = d; DVALID = 1'b1;
    @(negedge CLK);
    DVALID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_tests++; if (DREADY !== 1'b1) begin n_fail++; $display("FAIL rst_dready got %b want 1", DREADY); end
    n_tests++; if (LED !== 8'hFF)   begin n_fail++; $display("FAIL rst_led got %h want ff", LED); end
    n_tests++; if (sa !== 4'hF)     begin n_fail++; $display("FAIL rst_sa got %b want 1111", sa); end
    RSTN = 1'b1;
    repeat (FRAME + 2) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led) begin n_fail++; $display("FAIL rst_scan_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)   begin n_fail++; $display("FAIL rst_scan_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
    end
  endtask

  task automatic test_handshake();
    send(16'h1A8F, 4'b0000);
    repeat (2 * FRAME) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led)    begin n_fail++; $display("FAIL hs_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)      begin n_fail++; $display("FAIL hs_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
      n_tests++; if (DREADY !== !m_full) begin n_fail++; $display("FAIL hs_dready cyc=%0d got %b want %b", m_cyc, DREADY, !m_full); end
    end
  endtask

  task automatic test_frame_end_accept();
    int w = 0;
    @(negedge CLK);
    while (((m_cyc % FRAME) != FRAME - 1 || m_full) && w < 4 * FRAME) begin
      @(negedge CLK);
      w++;
    end
    n_tests++;
    if ((m_cyc % FRAME) != FRAME - 1 || DREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL fe_align_timeout got DREADY=%b want 1", DREADY);
    end
    DIN = 16'($urandom); DP = 4'($urandom); DVALID = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led)    begin n_fail++; $display("FAIL fe_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)      begin n_fail++; $display("FAIL fe_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
      n_tests++; if (DREADY !== !m_full) begin n_fail++; $display("FAIL fe_dready cyc=%0d got %b want %b", m_cyc, DREADY, !m_full); end
      // A second request lands while the first is still pending.
      DVALID = (i == 3);
      if (i == 3) DIN = ~DIN;
    end
  endtask

  task automatic test_dp();
    send(16'h0000, 4'b0100);
    repeat (2 * FRAME) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led) begin n_fail++; $display("FAIL dp_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)   begin n_fail++; $display("FAIL dp_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
    end
  endtask

  task automatic test_blank();
    send(16'hC3E5, 4'b1001);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led) begin n_fail++; $display("FAIL blank_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)   begin n_fail++; $display("FAIL blank_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
      BLANK = (i >= FRAME + 2 && i < FRAME + 7) || ($urandom_range(0, 7) == 0);
    end
    BLANK = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [3:0]  d;
    for (int k = 0; k < 6; k++) begin
      v = 16'($urandom) >> (4 * $urandom_range(0, 3));
      d = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      send(v, d);
      repeat (2 * FRAME) begin
        @(negedge CLK);
        n_tests++; if (LED !== exp_led)    begin n_fail++; $display("FAIL rnd_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
        n_tests++; if (sa !== exp_sa)      begin n_fail++; $display("FAIL rnd_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
        n_tests++; if (DREADY !== !m_full) begin n_fail++; $display("FAIL rnd_dready cyc=%0d got %b want %b", m_cyc, DREADY, !m_full); end
      end
    end
  endtask

  task automatic test_reset_mid_handshake();
    send(16'h8421, 4'b0010);
    n_tests++; if (DREADY !== 1'b0) begin n_fail++; $display("FAIL mrst_pending got DREADY=%b want 0", DREADY); end
    #2 RSTN = 1'b0;
    #1;
    n_tests++; if (DREADY !== 1'b1) begin n_fail++; $display("FAIL mrst_dready got %b want 1", DREADY); end
    n_tests++; if (LED !== 8'hFF)   begin n_fail++; $display("FAIL mrst_led got %h want ff", LED); end
    n_tests++; if (sa !== 4'hF)     begin n_fail++; $display("FAIL mrst_sa got %b want 1111", sa); end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2 * FRAME) begin
      @(negedge CLK);
      n_tests++; if (LED !== exp_led)    begin n_fail++; $display("FAIL mrst_scan_led cyc=%0d got %h want %h", m_cyc, LED, exp_led); end
      n_tests++; if (sa !== exp_sa)      begin n_fail++; $display("FAIL mrst_scan_sa cyc=%0d got %b want %b", m_cyc, sa, exp_sa); end
      n_tests++; if (DREADY !== !m_full) begin n_fail++; $display("FAIL mrst_scan_dready cyc=%0d got %b want %b", m_cyc, DREADY, !m_full); end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_frame_end_accept();
    test_dp();
    test_blank();
    test_random();
    test_reset_mid_handshake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
